// File: rtl/result_pack_ctrl.sv
// result_pack_ctrl
//   Receive side of the multiplier-tree result stream. It collects one node's
//   64-bit beats (four bf16 lanes each) into a beat buffer and waits for the
//   node's max exponent. It then reads the beats back and rescales every lane
//   so that the node maximum lands on exponent 127. Four normalised beats are
//   packed into each 256-bit line, which is sent downstream over valid/ready.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   in_data[63:0], in_vld          incoming beat (lane k = bits [16k+15:16k])
//   num_of_line_per_node_minusone  beats per node minus one (N)
//   max_exponent, max_exponent_vld node max exponent and its one-cycle pulse
//   out_data[255:0], out_vld       packed line (beat j = bits [64j+63:64j])
//   out_ready                      downstream accept
//   out_last                       final line of the node
//   state[1:0]                     0 COLLECT, 1 WAIT_EXP, 2 DRAIN
//   overflow_err                   sticky: a beat arrived outside COLLECT
module result_pack_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       in_data,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] num_of_line_per_node_minusone,
  input  logic [7:0]        max_exponent,
  input  logic              max_exponent_vld,
  output logic [255:0]      out_data,
  output logic              out_vld,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        state,
  output logic              overflow_err
);

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    WAIT_EXP = 2'd1,
    DRAIN    = 2'd2
  } st_t;

  st_t               st;
  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] n_lat;
  logic [ADDR_W-1:0] n_eff;
  logic [7:0]        exp_max;
  logic              exp_cap;
  logic              rd_done;
  logic [2:0]        alloc_cnt;

  logic              rd_vld_p1;
  logic [1:0]        rd_slot_p1;
  logic              rd_last_p1;
  logic              rd_gend_p1;
  logic [63:0]       rd_data_p1;

  logic [255:0]      asm_data;
  logic [255:0]      asm_merge;
  logic              asm_full;
  logic              asm_last;

  logic              wr_en;
  logic              wr_final;
  logic              enter_drain;
  logic              out_free;
  logic              grp_done_now;
  logic              xfer;
  logic              rd_en;
  logic [1:0]        rd_slot;
  logic              rd_final;
  logic              node_end;

  // Rescale one bf16 lane against the node maximum m.
  function automatic logic [15:0] norm_lane(input logic [15:0] v, input logic [7:0] m);
    logic [8:0]  d;
    logic [7:0]  e;
    logic [15:0] r;
    e = v[14:7];
    d = {1'b0, m} - {1'b0, e};
    if (e == 8'd0)
      r = {v[15], 15'd0};
    else if (e == 8'hFF)
      r = v;
    else if (d[8])
      // borrow means e > m: saturate to the top of the range
      r = {v[15], 8'd127, v[6:0]};
    else if (d >= 9'd127)
      r = {v[15], 15'd0};
    else
      r = {v[15], 8'd127 - d[7:0], v[6:0]};
    return r;
  endfunction

  function automatic logic [63:0] norm_beat(input logic [63:0] b, input logic [7:0] m);
    logic [63:0] r;
    for (int k = 0; k < 4; k++)
      r[16*k +: 16] = norm_lane(b[16*k +: 16], m);
    return r;
  endfunction

  assign state = st;

  assign wr_en       = in_vld && (st == COLLECT);
  assign n_eff       = (wr_cnt == '0) ? num_of_line_per_node_minusone : n_lat;
  assign wr_final    = wr_en && (wr_cnt == n_eff);
  assign enter_drain = (wr_final && (exp_cap || max_exponent_vld)) ||
                       ((st == WAIT_EXP) && exp_cap);

  // A group leaves the assembly register either when it is already complete
  // or in the very cycle its closing beat lands, so the next group's first
  // read can be issued alongside the transfer and no bubble appears.
  assign out_free     = !out_vld || out_ready;
  assign grp_done_now = rd_vld_p1 && rd_gend_p1;
  assign xfer         = (st == DRAIN) && out_free && (asm_full || grp_done_now);
  assign rd_en        = (st == DRAIN) && !rd_done && ((alloc_cnt < 3'd4) || xfer);
  assign rd_slot      = xfer ? 2'd0 : alloc_cnt[1:0];
  assign rd_final     = (rd_cnt == n_lat);
  assign node_end     = out_vld && out_ready && out_last;

  always_comb begin
    asm_merge = asm_data;
    if (rd_vld_p1)
      asm_merge[64*rd_slot_p1 +: 64] = norm_beat(rd_data_p1, exp_max);
  end

  // Beat buffer and assembly data (no reset; contents are don't-care)
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_cnt] <= in_data;
    if (rd_en)
      rd_data_p1 <= mem[rd_cnt];
    if (enter_drain || xfer)
      asm_data <= '0;
    else if (rd_vld_p1)
      asm_data <= asm_merge;
  end

  // Control, FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= COLLECT;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      n_lat        <= '0;
      exp_max      <= '0;
      exp_cap      <= 1'b0;
      rd_done      <= 1'b0;
      alloc_cnt    <= '0;
      rd_vld_p1    <= 1'b0;
      rd_slot_p1   <= '0;
      rd_last_p1   <= 1'b0;
      rd_gend_p1   <= 1'b0;
      asm_full     <= 1'b0;
      asm_last     <= 1'b0;
      out_vld      <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (in_vld && (st != COLLECT))
        overflow_err <= 1'b1;

      if (((st == COLLECT) || (st == WAIT_EXP)) && max_exponent_vld) begin
        exp_max <= max_exponent;
        exp_cap <= 1'b1;
      end

      // read issue -> p1 (buffer data valid)
      rd_vld_p1 <= rd_en;
      if (rd_en) begin
        rd_slot_p1 <= rd_slot;
        rd_last_p1 <= rd_final;
        rd_gend_p1 <= (rd_slot == 2'd3) || rd_final;
        rd_cnt     <= rd_cnt + 1'b1;
        if (rd_final)
          rd_done <= 1'b1;
      end

      if (xfer)
        alloc_cnt <= rd_en ? 3'd1 : 3'd0;
      else if (rd_en)
        alloc_cnt <= alloc_cnt + 3'd1;

      // p1 -> assembly / output line
      if (xfer) begin
        asm_full <= 1'b0;
      end else if (grp_done_now) begin
        asm_full <= 1'b1;
        asm_last <= rd_last_p1;
      end

      if (xfer) begin
        out_vld  <= 1'b1;
        out_data <= asm_merge;
        out_last <= grp_done_now ? rd_last_p1 : asm_last;
      end else if (out_ready) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end

      case (st)
        COLLECT: begin
          if (wr_en) begin
            if (wr_cnt == '0)
              n_lat <= num_of_line_per_node_minusone;
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_final)
              st <= (exp_cap || max_exponent_vld) ? DRAIN : WAIT_EXP;
          end
        end
        WAIT_EXP: begin
          if (exp_cap)
            st <= DRAIN;
        end
        DRAIN: begin
          if (node_end) begin
            st        <= COLLECT;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rd_done   <= 1'b0;
            exp_cap   <= 1'b0;
            alloc_cnt <= '0;
          end
        end
        default: st <= COLLECT;
      endcase
    end
  end

endmodule
